// File: rtl/subtract_8bit_if.sv
// Operand/result bundle for subtract_8bit: one qualified operand set in,
// one registered result set out.
interface subtract_8bit_if;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic       b_in;
  logic [7:0] d;
  logic       b_out;
  logic       out_valid;
  logic       zero;
  logic       ovf;

  modport master (
    output in_valid, a, b, b_in,
    input  d, b_out, out_valid, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, b_in,
    output d, b_out, out_valid, zero, ovf
  );
endinterface

// File: rtl/subtract_8bit.sv
// Registered 8-bit ripple-borrow subtractor: {b_out,d} = a - b - b_in, 1-cycle latency.
// Optional zero/ovf flags are built only when SUBTRACT_8BIT_FLAGS_EN is defined.

module subtract_8bit_cell (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);
  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);
endmodule

module subtract_8bit (
  input  logic            clk,
  input  logic            rst_n,
  subtract_8bit_if.slave  bus
);
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         b_out;
  } rsp_t;

  logic [W:0]   br;
  logic [W-1:0] d_nxt;
  rsp_t         rsp_nxt;
  rsp_t         rsp_q;
  logic         vld_q;

  assign br[0] = bus.b_in;

  // Ripple chain: each cell hands its borrow to the next more-significant bit.
  for (genvar i = 0; i < W; i++) begin : g_cell
    subtract_8bit_cell u_cell (
      .a      (bus.a[i]),
      .b      (bus.b[i]),
      .br_in  (br[i]),
      .d      (d_nxt[i]),
      .br_out (br[i+1])
    );
  end

  always_comb begin
    rsp_nxt       = '0;
    rsp_nxt.d     = d_nxt;
    rsp_nxt.b_out = br[W];
  end

  // out_valid tracks in_valid every edge; the result only moves on a valid edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) rsp_q <= rsp_nxt;
    end
  end

  assign bus.d         = rsp_q.d;
  assign bus.b_out     = rsp_q.b_out;
  assign bus.out_valid = vld_q;

`ifdef SUBTRACT_8BIT_FLAGS_EN
  logic zero_q;
  logic ovf_q;
  logic zero_nxt;
  logic ovf_nxt;

  // Signed overflow: operand signs differ and the result sign departs from a.
  assign zero_nxt = (d_nxt == '0);
  assign ovf_nxt  = (bus.a[W-1] != bus.b[W-1]) & (d_nxt[W-1] != bus.a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.in_valid) begin
      zero_q <= zero_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`else
  assign bus.zero = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_subtract_8bit.sv
// Directed + random bench for subtract_8bit; expected results come from a
// 9-bit arithmetic model and a signed range check, queued per valid input.
module tb_subtract_8bit;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  subtract_8bit_if bus ();

  subtract_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef SUBTRACT_8BIT_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       b_out;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic bi);
    exp_t       e;
    logic [8:0] r;
    int         s;
    r       = {1'b0, a} - {1'b0, b} - {8'b0, bi};
    s       = int'($signed(a)) - int'($signed(b)) - int'(bi);
    e.d     = r[7:0];
    e.b_out = r[8];
    e.zero  = FLAGS && (r[7:0] == 8'h00);
    e.ovf   = FLAGS && (s < -128 || s > 127);
    return e;
  endfunction

  task automatic check(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string tag, logic v);
    exp_t e;
    check({tag, ".out_valid"}, {8'b0, bus.out_valid}, {8'b0, v});
    e = last;
    if (v) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s.scoreboard: observed empty expected entry", tag);
      end else begin
        e = sb.pop_front();
      end
      last = e;
    end
    check({tag, ".d"},     {1'b0, bus.d},     {1'b0, e.d});
    check({tag, ".b_out"}, {8'b0, bus.b_out}, {8'b0, e.b_out});
    check({tag, ".zero"},  {8'b0, bus.zero},  {8'b0, e.zero});
    check({tag, ".ovf"},   {8'b0, bus.ovf},   {8'b0, e.ovf});
  endtask

  task automatic step(string tag, logic v, logic [7:0] a, logic [7:0] b, logic bi);
    @(negedge clk);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.b_in     = bi;
    if (v) sb.push_back(model(a, b, bi));
    @(posedge clk);
    #1;
    check_out(tag, v);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    bus.b_in     = 1'b0;
    last         = '0;
    #12;
    check_out("reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    step("first",    1'b1, 8'h01, 8'h01, 1'b0);
    step("chain_a",  1'b1, 8'h03, 8'h05, 1'b1);
    step("chain_b",  1'b1, 8'h01, 8'h01, 1'b1);
    step("chain_c",  1'b1, 8'h03, 8'h03, 1'b1);
    step("mix_a",    1'b1, 8'h19, 8'h31, 1'b0);
    step("mix_b",    1'b1, 8'h31, 8'h19, 1'b0);
    step("mix_c",    1'b1, 8'h81, 8'h81, 1'b0);
    step("ext_a",    1'b1, 8'hFF, 8'h01, 1'b0);
    step("ext_b",    1'b1, 8'hFF, 8'h00, 1'b1);
    step("ext_c",    1'b1, 8'hFF, 8'hFF, 1'b0);
    step("flag_a",   1'b1, 8'h80, 8'h01, 1'b0);
    step("flag_b",   1'b1, 8'h7F, 8'hFF, 1'b0);
    step("hold_a",   1'b0, 8'hAA, 8'h55, 1'b1);
    step("hold_b",   1'b0, 8'h00, 8'h00, 1'b0);
    step("zero_bin", 1'b1, 8'h00, 8'h00, 1'b1);

    for (int i = 0; i < 24; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Mid-stream asynchronous reset, asserted between edges with a valid input pending.
    step("pre_rst", 1'b1, 8'h10, 8'h01, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'h20;
    bus.b        = 8'h01;
    bus.b_in     = 1'b0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    last = '0;
    #1;
    check_out("async_rst", 1'b0);
    @(posedge clk);
    #1;
    check_out("rst_held", 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step("post_rst", 1'b1, 8'h02, 8'h01, 1'b0);
    step("post_idle", 1'b0, 8'h77, 8'h11, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
